// File: rtl/plot_sweep_controller.sv
// plot_sweep_controller: drives stack_machine across every screen column and
// writes {in_range, row} per column into the renderer's Y buffer.
module plot_sweep_controller #(
    parameter int INTEGER_PART_WIDTH    = 8,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int HOR_ACTIVE_PIXELS     = 640,
    parameter int VER_ACTIVE_PIXELS     = 480,
    parameter int TIMEOUT_CYCLES        = 4096,
    localparam int NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    localparam int AW = $clog2(HOR_ACTIVE_PIXELS),
    localparam int RW = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          expr_valid,
    input  logic          continuous,
    output logic          sm_start,
    output logic [NW-1:0] sm_x,
    input  logic          sm_ready,
    input  logic [NW-1:0] sm_y,
    output logic          buf_we,
    output logic [AW-1:0] buf_addr,
    output logic [RW:0]   buf_data,
    output logic          busy,
    output logic          sweep_done,
    output logic          error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [NW-1:0] VER_N      = NW'(VER_ACTIVE_PIXELS);
    localparam logic [RW-1:0] ROW_MAX    = RW'(VER_ACTIVE_PIXELS - 1);
    localparam logic [AW-1:0] COL_LAST   = AW'(HOR_ACTIVE_PIXELS - 1);
    // The ISSUE cycle is part of the wait budget, so WAIT gives up one early.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, WRITE, DONE, ERROR
    } state_t;

    state_t        state;
    logic [AW-1:0] col;
    logic [AW-1:0] col_nxt;
    logic [TW-1:0] timer;
    logic          pending;
    logic          restart;
    logic          y_in_range;
    logic [RW-1:0] y_row;

    assign col_nxt = col + AW'(1);
    assign restart = pending | expr_valid;

    always_comb begin
        y_in_range = !sm_y[NW-1] && (sm_y < VER_N);
        y_row      = '0;
        if (y_in_range) begin
            y_row = ROW_MAX - sm_y[RW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            timer      <= '0;
            pending    <= 1'b0;
            sm_start   <= 1'b0;
            sm_x       <= '0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            sm_start   <= 1'b0;
            buf_we     <= 1'b0;
            sweep_done <= 1'b0;
            if (busy && expr_valid) begin
                pending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (expr_valid) begin
                        col      <= '0;
                        sm_x     <= '0;
                        sm_start <= 1'b1;
                        busy     <= 1'b1;
                        pending  <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (sm_ready) begin
                        buf_we   <= 1'b1;
                        buf_addr <= col;
                        buf_data <= {y_in_range, y_row};
                        state    <= WRITE;
                    end else if (timer == TIMER_LAST) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        pending <= 1'b0;
                        state   <= ERROR;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WRITE: begin
                    if (restart) begin
                        pending  <= 1'b0;
                        col      <= '0;
                        sm_x     <= '0;
                        sm_start <= 1'b1;
                        state    <= ISSUE;
                    end else if (col == COL_LAST) begin
                        sweep_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        col      <= col_nxt;
                        sm_x     <= NW'(col_nxt);
                        sm_start <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                DONE: begin
                    if (restart || continuous) begin
                        pending  <= 1'b0;
                        col      <= '0;
                        sm_x     <= '0;
                        sm_start <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ERROR: begin
                    pending <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_plot_sweep_controller.sv
// Scoreboard bench for plot_sweep_controller: a 4-column, 8-row screen
// driven by a stub stack_machine that answers three cycles after start.
module tb_plot_sweep_controller;

    localparam int HOR = 4;
    localparam int VER = 8;
    localparam int TMO = 16;
    localparam int NW  = 16;
    localparam int AW  = 2;
    localparam int RW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          expr_valid = 1'b0;
    logic          continuous = 1'b0;
    logic          sm_ready = 1'b0;
    logic [NW-1:0] sm_y = '0;
    logic          sm_start;
    logic [NW-1:0] sm_x;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [RW:0]   buf_data;
    logic          busy;
    logic          sweep_done;
    logic          error;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_x[$];
    logic [AW+RW:0] exp_w[$];
    logic [NW-1:0]  y_ovr[$];
    logic [NW-1:0]  stub_y;
    bit stub_en = 1'b1;
    logic prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    plot_sweep_controller #(
        .INTEGER_PART_WIDTH   (8),
        .FRACTIONAL_PART_WIDTH(8),
        .HOR_ACTIVE_PIXELS    (HOR),
        .VER_ACTIVE_PIXELS    (VER),
        .TIMEOUT_CYCLES       (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .expr_valid(expr_valid),
        .continuous(continuous),
        .sm_start  (sm_start),
        .sm_x      (sm_x),
        .sm_ready  (sm_ready),
        .sm_y      (sm_y),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .busy      (busy),
        .sweep_done(sweep_done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_sweep();
        for (int i = 0; i < HOR; i++) begin
            exp_x.push_back(i);
            exp_w.push_back({AW'(i), 1'b1, RW'(VER - 1 - i)});
        end
    endtask

    task automatic pulse_ev();
        @(negedge clk);
        expr_valid = 1'b1;
        @(negedge clk);
        expr_valid = 1'b0;
    endtask

    task automatic wait_start(input int x);
        int n;
        n = 0;
        while (!(sm_start && int'(sm_x) == x) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL wait_start: no sm_start with sm_x=%0d", x);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!sweep_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_done: sweep_done never seen");
        end
    endtask

    // stub stack_machine
    initial begin
        forever begin
            @(negedge clk);
            if (sm_start && stub_en) begin
                if (y_ovr.size() > 0) stub_y = y_ovr.pop_front();
                else stub_y = sm_x;
                repeat (3) @(negedge clk);
                sm_y = stub_y;
                sm_ready = 1'b1;
                @(negedge clk);
                sm_ready = 1'b0;
                sm_y = '0;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (sm_start) begin
                if (exp_x.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sm_start: got sm_x=%0d, expected no start", sm_x);
                end else begin
                    check("sm_x", int'(sm_x), exp_x.pop_front());
                end
            end
            if (buf_we) begin
                if (exp_w.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL buf_we: got addr=%0d data=%0h, expected no write",
                             buf_addr, buf_data);
                end else begin
                    check("buf_write", int'({buf_addr, buf_data}), int'(exp_w.pop_front()));
                end
            end
            if (sweep_done) begin
                done_cnt++;
                check("done_after_last_we", int'({prev_we, prev_addr}),
                      int'({1'b1, AW'(HOR - 1)}));
            end
            prev_we = buf_we;
            prev_addr = buf_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        check("rst_outputs", int'({sm_start, sm_x, buf_we, buf_addr, buf_data}), 0);
        check("rst_flags", int'({busy, sweep_done, error}), 0);
        rst = 1'b0;

        // basic sweep, y = x
        push_sweep();
        pulse_ev();
        check("busy_start", int'(busy), 1);
        wait_done();
        @(negedge clk);
        check("busy_end", int'(busy), 0);

        // row mapping edges: -1, 8, 7, then 3
        y_ovr.push_back(16'hFFFF);
        y_ovr.push_back(16'd8);
        y_ovr.push_back(16'd7);
        for (int i = 0; i < HOR; i++) exp_x.push_back(i);
        exp_w.push_back(6'b00_0000);
        exp_w.push_back(6'b01_0000);
        exp_w.push_back(6'b10_1000);
        exp_w.push_back(6'b11_1100);
        pulse_ev();
        wait_done();
        @(negedge clk);

        // two restarts during WAIT of col 2 collapse to one
        for (int i = 0; i < 3; i++) begin
            exp_x.push_back(i);
            exp_w.push_back({AW'(i), 1'b1, RW'(VER - 1 - i)});
        end
        push_sweep();
        pulse_ev();
        wait_start(2);
        @(negedge clk);
        expr_valid = 1'b1;
        @(negedge clk);
        expr_valid = 1'b0;
        @(negedge clk);
        expr_valid = 1'b1;
        @(negedge clk);
        expr_valid = 1'b0;
        wait_done();
        @(negedge clk);
        check("done_cnt_pending", done_cnt, 3);

        // timeout
        stub_en = 1'b0;
        exp_x.push_back(0);
        pulse_ev();
        wait_start(0);
        cnt = 0;
        while (!error && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_cycles", cnt, 16);
        check("timeout_busy", int'(busy), 0);
        pulse_ev();
        repeat (10) @(negedge clk);
        check("error_sticky", int'({error, busy}), 2);
        #2 rst = 1'b1;
        #1 check("rst_clears_error", int'(error), 0);
        @(negedge clk);
        rst = 1'b0;
        stub_en = 1'b1;

        // continuous mode
        continuous = 1'b1;
        push_sweep();
        push_sweep();
        pulse_ev();
        wait_done();
        @(negedge clk);
        check("cont_restart", int'({sm_start, sm_x}), int'({1'b1, 16'd0}));
        continuous = 1'b0;
        wait_done();
        @(negedge clk);
        check("cont_end_busy", int'(busy), 0);

        // asynchronous reset in WAIT of col 1
        exp_x.push_back(0);
        exp_x.push_back(1);
        exp_w.push_back({2'd0, 1'b1, 3'd7});
        pulse_ev();
        wait_start(1);
        @(negedge clk);
        check("busy_before_rst", int'({busy, sm_x}), int'({1'b1, 16'd1}));
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", int'({sm_start, sm_x, buf_we, buf_addr, buf_data}), 0);
        check("async_rst_flags", int'({busy, sweep_done, error}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        check("exp_x_drained", exp_x.size(), 0);
        check("exp_w_drained", exp_w.size(), 0);
        check("done_cnt_total", done_cnt, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
